ricosoc_bus_decoder: RTL and testbench

Parametrised native-memory-bus interconnect between the picorv32 mem_* port and NUM_SLAVES slave regions. It is the successor to the fixed RAM/ROM/iomem decode in the SoC top level. It decodes each CPU request against per-slave base/mask pairs and forwards it to exactly one slave. It registers the response and returns ERR_RDATA with an error interrupt for unmapped addresses or slave timeouts, so the CPU never hangs on a dead address.

---
 rtl/ricosoc_bus_pkg.sv | 18 +
 rtl/ricosoc_addr_match.sv | 25 ++
 rtl/ricosoc_bus_decoder.sv | 121 ++++++++++++
 tb/tb_ricosoc_bus_decoder.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/ricosoc_bus_pkg.sv
// rtl/ricosoc_bus_pkg.sv - shared state encoding and default memory map for the bus decoder
package ricosoc_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2,
    ST_ERR    = 2'd3
  } bus_state_e;

  localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

  localparam logic [31:0] RAM_BASE    = 32'h0000_0000;
  localparam logic [31:0] ROM_BASE    = 32'h0100_0000;
  localparam logic [31:0] EXT_BASE    = 32'h0200_0000;
  localparam logic [31:0] REGION_MASK = 32'hFF00_0000;

endpackage

// File: rtl/ricosoc_addr_match.sv
// rtl/ricosoc_addr_match.sv - combinational base/mask region matcher, lowest index wins
module ricosoc_addr_match #(
  parameter int                         NUM_SLAVES = 3,
  parameter int                         SEL_W      = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1,
  parameter logic [NUM_SLAVES*32-1:0]   SLAVE_BASE = '0,
  parameter logic [NUM_SLAVES*32-1:0]   SLAVE_MASK = '0
) (
  input  logic [31:0]      addr,
  output logic             hit,
  output logic [SEL_W-1:0] sel
);

  // Scan from the top down so the lowest matching index is the last one written.
  always_comb begin
    hit = 1'b0;
    sel = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((addr & SLAVE_MASK[32*i +: 32]) == SLAVE_BASE[32*i +: 32]) begin
        hit = 1'b1;
        sel = SEL_W'(i);
      end
    end
  end

endmodule

// File: rtl/ricosoc_bus_decoder.sv
// rtl/ricosoc_bus_decoder.sv - picorv32 native bus interconnect with unmapped/timeout error responses
module ricosoc_bus_decoder
  import ricosoc_bus_pkg::*;
#(
  parameter int                       NUM_SLAVES     = 3,
  parameter logic [NUM_SLAVES*32-1:0] SLAVE_BASE     = {EXT_BASE, ROM_BASE, RAM_BASE},
  parameter logic [NUM_SLAVES*32-1:0] SLAVE_MASK     = {3{REGION_MASK}},
  parameter int                       TIMEOUT_CYCLES = 64,
  parameter logic [31:0]              ERR_RDATA      = ERR_RDATA_DEFAULT
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       m_valid,
  input  logic                       m_instr,
  input  logic [31:0]                m_addr,
  input  logic [31:0]                m_wdata,
  input  logic [3:0]                 m_wstrb,
  output logic                       m_ready,
  output logic [31:0]                m_rdata,
  output logic [NUM_SLAVES-1:0]      s_valid,
  output logic                       s_instr,
  output logic [31:0]                s_addr,
  output logic [31:0]                s_wdata,
  output logic [3:0]                 s_wstrb,
  input  logic [NUM_SLAVES-1:0]      s_ready,
  input  logic [NUM_SLAVES*32-1:0]   s_rdata,
  input  logic                       err_clr,
  output logic                       bus_err_irq,
  output logic [31:0]                err_addr,
  output logic [7:0]                 err_count
);

  localparam int SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

  bus_state_e    state, state_nx;
  logic          hit;
  logic [SW-1:0] hit_sel;
  logic [SW-1:0] sel;
  logic [CW-1:0] cnt;
  logic          sel_ready;
  logic          timeout;

  ricosoc_addr_match #(
    .NUM_SLAVES (NUM_SLAVES),
    .SEL_W      (SW),
    .SLAVE_BASE (SLAVE_BASE),
    .SLAVE_MASK (SLAVE_MASK)
  ) u_match (
    .addr (m_addr),
    .hit  (hit),
    .sel  (hit_sel)
  );

  // Only the selected slave's ready matters; the others are ignored.
  assign sel_ready = s_ready[sel];
  assign timeout   = (TIMEOUT_CYCLES != 0) && (cnt == TO_LAST);

  // Outputs decode straight from state so an async reset clears them at once.
  assign m_ready     = (state == ST_RESP) || (state == ST_ERR);
  assign bus_err_irq = (state == ST_ERR);
  assign s_valid     = (state == ST_ACCESS) ? (NUM_SLAVES'(1) << sel) : '0;

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nx;
  end

  // Next-state logic; a ready arriving on the timeout cycle still wins.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (m_valid) state_nx = hit ? ST_ACCESS : ST_ERR;
      ST_ACCESS: begin
        if (sel_ready)    state_nx = ST_RESP;
        else if (timeout) state_nx = ST_ERR;
      end
      ST_RESP:   state_nx = ST_IDLE;
      ST_ERR:    state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  // Request capture, response data, timeout counter and error bookkeeping.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s_instr   <= 1'b0;
      s_addr    <= '0;
      s_wdata   <= '0;
      s_wstrb   <= '0;
      sel       <= '0;
      cnt       <= '0;
      m_rdata   <= '0;
      err_addr  <= '0;
      err_count <= '0;
    end else begin
      if (state == ST_IDLE && m_valid) begin
        s_instr <= m_instr;
        s_addr  <= m_addr;
        s_wdata <= m_wdata;
        s_wstrb <= m_wstrb;
        sel     <= hit_sel;
        cnt     <= '0;
        if (!hit) m_rdata <= ERR_RDATA;
      end
      if (state == ST_ACCESS) begin
        if (sel_ready)    m_rdata <= s_rdata[32*sel +: 32];
        else if (timeout) m_rdata <= ERR_RDATA;
        else              cnt     <= cnt + CW'(1);
      end
      if (state == ST_ERR) err_addr <= s_addr;
      if (err_clr)
        err_count <= (state == ST_ERR) ? 8'd1 : 8'd0;
      else if (state == ST_ERR && err_count != 8'hFF)
        err_count <= err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_ricosoc_bus_decoder.sv
// tb/tb_ricosoc_bus_decoder.sv - scoreboard bench for ricosoc_bus_decoder
module tb_ricosoc_bus_decoder;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        m_valid = 1'b0;
  logic        m_instr = 1'b0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_wdata = '0;
  logic [3:0]  m_wstrb = '0;
  logic        m_ready;
  logic [31:0] m_rdata;
  logic [2:0]  s_valid;
  logic        s_instr;
  logic [31:0] s_addr;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic [2:0]  s_ready = '0;
  logic [95:0] s_rdata = '0;
  logic        err_clr = 1'b0;
  logic        bus_err_irq;
  logic [31:0] err_addr;
  logic [7:0]  err_count;

  int tests = 0;
  int fails = 0;
  logic [32:0] sbq[$];

  ricosoc_bus_decoder dut (
    .clk(clk), .resetn(resetn),
    .m_valid(m_valid), .m_instr(m_instr), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_ready(m_ready), .m_rdata(m_rdata),
    .s_valid(s_valid), .s_instr(s_instr), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_ready(s_ready), .s_rdata(s_rdata),
    .err_clr(err_clr), .bus_err_irq(bus_err_irq), .err_addr(err_addr), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every response strobe pops one expected {irq, rdata}.
  initial begin
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (resetn && m_ready) begin
        if (sbq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL sb_unexpected: got m_ready with rdata %h, expected no response", m_rdata);
        end else begin
          e = sbq.pop_front();
          check("sb_rdata", m_rdata, e[31:0]);
          check("sb_irq", {31'd0, bus_err_irq}, {31'd0, e[32]});
        end
      end
    end
  end

  // One CPU transaction. sv = expected one-hot slave (0 = unmapped), rdy = ACCESS
  // cycle (1-based) in which the slave answers, -1 = never; spur = stray readies.
  task automatic access(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                        input logic [2:0] sv, input int rdy, input logic [31:0] rdata,
                        input logic [2:0] spur, input logic clr, input string name);
    int acc, lat, exp_acc;
    bit ok, bad;
    ok      = (sv != 0) && (rdy >= 1) && (rdy <= 64);
    exp_acc = (sv == 0) ? 0 : (ok ? rdy : 64);
    sbq.push_back({!ok, ok ? rdata : 32'hDEAD_BEEF});
    @(negedge clk);
    m_valid = 1'b1; m_addr = addr; m_wdata = wdata; m_wstrb = wstrb; err_clr = clr;
    s_ready = spur;
    s_rdata = {3{~rdata}};
    for (int i = 0; i < 3; i++) if (sv[i]) s_rdata[32*i +: 32] = rdata;
    acc = 0; lat = -1; bad = 0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (m_ready) begin
        lat = c; m_valid = 1'b0; s_ready = '0; err_clr = 1'b0;
        break;
      end
      if (s_valid != 0) begin
        acc++;
        if (s_valid !== sv) bad = 1;
        if (acc == 1) begin
          check({name, "_s_addr"}, s_addr, addr);
          check({name, "_s_wstrb"}, {28'd0, s_wstrb}, {28'd0, wstrb});
          check({name, "_s_wdata"}, s_wdata, wdata);
        end
      end
      s_ready = (s_valid != 0 && acc == rdy) ? (sv | spur) : spur;
    end
    m_valid = 1'b0; err_clr = 1'b0;
    check({name, "_latency"}, lat, exp_acc + 1);
    check({name, "_access_cycles"}, acc, exp_acc);
    check({name, "_s_valid_onehot"}, {31'd0, bad}, 32'd0);
  endtask

  initial begin
    #2;
    check("rst_m_ready", {31'd0, m_ready}, 32'd0);
    check("rst_s_valid", {29'd0, s_valid}, 32'd0);
    check("rst_m_rdata", m_rdata, 32'd0);
    check("rst_irq", {31'd0, bus_err_irq}, 32'd0);
    check("rst_err_addr", err_addr, 32'd0);
    check("rst_err_count", {24'd0, err_count}, 32'd0);
    @(negedge clk); @(negedge clk);
    resetn = 1'b1;

    access(32'h0000_0010, 32'h0, 4'h0, 3'b001, 1, 32'h1234_5678, 3'b000, 1'b0, "rd_s0");
    access(32'h0100_0004, 32'hA5A5_A5A5, 4'b0011, 3'b010, 6, 32'h0BAD_F00D, 3'b000, 1'b0, "wr_s1");
    check("no_err_after_hits", {24'd0, err_count}, 32'd0);

    access(32'h0300_0000, 32'h0, 4'h0, 3'b000, 1, 32'h0, 3'b000, 1'b0, "unmapped");
    @(negedge clk);
    check("unmapped_err_count", {24'd0, err_count}, 32'd1);
    check("unmapped_err_addr", err_addr, 32'h0300_0000);

    access(32'h0200_0000, 32'h0, 4'h0, 3'b100, -1, 32'h7777_7777, 3'b000, 1'b0, "timeout_s2");
    @(negedge clk);
    check("timeout_err_count", {24'd0, err_count}, 32'd2);
    check("timeout_err_addr", err_addr, 32'h0200_0000);

    access(32'h0200_0010, 32'h0, 4'h0, 3'b100, 64, 32'hCAFE_F00D, 3'b001, 1'b0, "rd_s2_edge");
    @(negedge clk);
    check("edge_err_count", {24'd0, err_count}, 32'd2);

    access(32'h0F00_0008, 32'h1111_2222, 4'hF, 3'b000, 1, 32'h0, 3'b000, 1'b0, "wr_unmapped");
    @(negedge clk);
    check("wr_unmapped_err_count", {24'd0, err_count}, 32'd3);

    for (int n = 0; n < 300; n++)
      access(32'h0400_0000 + n, 32'h0, 4'h0, 3'b000, 1, 32'h0, 3'b000, 1'b0, "sat");
    @(negedge clk);
    check("sat_err_count", {24'd0, err_count}, 32'd255);

    access(32'h0500_0000, 32'h0, 4'h0, 3'b000, 1, 32'h0, 3'b000, 1'b1, "clr_on_err");
    @(negedge clk);
    check("clr_on_err_count", {24'd0, err_count}, 32'd1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("clr_idle_count", {24'd0, err_count}, 32'd0);

    m_valid = 1'b1; m_addr = 32'h0100_0000; m_wstrb = 4'h0; s_ready = '0;
    @(negedge clk); m_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    check("pre_reset_s_valid", {29'd0, s_valid}, 32'd2);
    #2 resetn = 1'b0;
    #1;
    check("async_rst_s_valid", {29'd0, s_valid}, 32'd0);
    check("async_rst_m_ready", {31'd0, m_ready}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    access(32'h0000_0020, 32'h0, 4'h0, 3'b001, 1, 32'h55AA_33CC, 3'b000, 1'b0, "post_reset_rd");

    @(negedge clk); @(negedge clk);
    check("sb_drained", sbq.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
